// File: rtl/modulus_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : modulus_seq_pkg
// Brief    : Shared types and constants for the fractional modulus sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package modulus_seq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam int c_ACC_W_DEFAULT = 8;

    // Dither polynomial x^15 + x^14 + 1: feedback from bits 14 and 13.
    localparam int                    c_LFSR_W    = 15;
    localparam logic [c_LFSR_W-1:0]   c_LFSR_TAPS = 15'h6000;

endpackage
`default_nettype wire

// File: rtl/dsm_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : dsm_lfsr
// Brief    : 15-bit Fibonacci LFSR supplying the dither bit; steps on advance.
// Revision : 1.0 - initial release
// ============================================================================
module dsm_lfsr
    import modulus_seq_pkg::*;
#(
    parameter logic [c_LFSR_W-1:0] SEED = 15'h4A5B
) (
    input  logic clk,
    input  logic rst_n,
    input  logic advance,
    output logic bit_out
);

    logic [c_LFSR_W-1:0] r_lfsr;
    logic                w_feedback;

    assign w_feedback = ^(r_lfsr & c_LFSR_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (advance) begin
            r_lfsr <= {r_lfsr[c_LFSR_W-2:0], w_feedback};
        end
    end

    assign bit_out = r_lfsr[0];

endmodule
`default_nettype wire

// File: rtl/modulus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : modulus_sequencer
// Brief    : First-order accumulator driving a 240/248 dual-modulus divider,
//            with optional LFSR dither and a post-update settle indicator.
// Revision : 1.0 - initial release
// ============================================================================
module modulus_sequencer
    import modulus_seq_pkg::*;
#(
    parameter int                  ACC_W         = c_ACC_W_DEFAULT,
    parameter int                  SETTLE_CYCLES = 64,
    parameter logic [c_LFSR_W-1:0] LFSR_SEED     = 15'h4A5B
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             dither_en,
    input  logic [ACC_W-1:0] frac_word,
    input  logic             frac_valid,
    output logic             frac_ready,
    output logic             select_mode,
    output logic             settled
);

    localparam int                c_CNT_W       = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_INIT = c_CNT_W'(SETTLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

    seq_state_t         r_state;
    seq_state_t         w_state_next;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_frac;
    logic               r_select;
    logic [c_CNT_W-1:0] r_settle_cnt;
    logic               w_accept;
    logic               w_running;
    logic               w_lfsr_advance;
    logic               w_lfsr_bit;
    logic               w_dither_bit;
    logic [ACC_W:0]     w_sum;

    assign frac_ready     = 1'b1;
    assign w_accept       = frac_valid & frac_ready;
    // Accumulate only on edges that keep us in RUN; the exit edge behaves as IDLE.
    assign w_running      = (r_state == RUN) & enable;
    assign w_lfsr_advance = (r_state == RUN) & dither_en;
    assign w_dither_bit   = dither_en & w_lfsr_bit;
    assign w_sum          = {1'b0, r_acc} + {1'b0, r_frac} + {{ACC_W{1'b0}}, w_dither_bit};

    dsm_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (w_lfsr_advance),
        .bit_out (w_lfsr_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        settled      = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) w_state_next = RUN;
            end
            RUN: begin
                if (!enable) w_state_next = IDLE;
                settled = (r_settle_cnt == '0);
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_frac       <= '0;
            r_select     <= 1'b0;
            r_settle_cnt <= c_SETTLE_INIT;
        end else begin
            if (w_accept) begin
                r_frac <= frac_word;
            end
            if (w_running) begin
                r_acc    <= w_sum[ACC_W-1:0];
                r_select <= w_sum[ACC_W];
                if (w_accept) begin
                    r_settle_cnt <= c_SETTLE_INIT;
                end else if (r_settle_cnt != '0) begin
                    r_settle_cnt <= r_settle_cnt - c_CNT_ONE;
                end
            end else begin
                r_acc        <= '0;
                r_select     <= 1'b0;
                r_settle_cnt <= c_SETTLE_INIT;
            end
        end
    end

    assign select_mode = r_select;

endmodule
`default_nettype wire

// File: tb/tb_modulus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_modulus_sequencer
// Brief    : Self-checking bench for modulus_sequencer against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modulus_sequencer;

    localparam int ACC_W = 8;
    localparam int S     = 64;
    localparam int MOD   = 1 << ACC_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             dither_en;
    logic [ACC_W-1:0] frac_word;
    logic             frac_valid;
    logic             frac_ready;
    logic             select_mode;
    logic             settled;

    int n_checks = 0;
    int n_fail   = 0;

    modulus_sequencer #(
        .ACC_W         (ACC_W),
        .SETTLE_CYCLES (S),
        .LFSR_SEED     (15'h4A5B)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .dither_en   (dither_en),
        .frac_word   (frac_word),
        .frac_valid  (frac_valid),
        .frac_ready  (frac_ready),
        .select_mode (select_mode),
        .settled     (settled)
    );

    always #5 clk = ~clk;

    // Behavioural model: fractional accumulation as plain integer arithmetic.
    bit          m_run;
    bit          m_sel;
    int          m_acc;
    int          m_frac;
    int          m_cnt;
    int          m_d;
    int          m_total;
    logic [14:0] m_lfsr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  = 1'b0;
            m_sel  = 1'b0;
            m_acc  = 0;
            m_frac = 0;
            m_cnt  = S;
            m_lfsr = 15'h4A5B;
        end else begin
            m_d = 0;
            if (m_run && dither_en) begin
                m_d    = int'(m_lfsr[0]);
                m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
            end
            if (m_run && enable) begin
                m_total = m_acc + m_frac + m_d;
                m_sel   = (m_total >= MOD);
                m_acc   = m_total % MOD;
                if (frac_valid)     m_cnt = S;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
            end else begin
                m_acc = 0;
                m_sel = 1'b0;
                m_cnt = S;
            end
            if (frac_valid) m_frac = int'(frac_word);
            m_run = enable;
        end
    end

    function automatic bit m_settled();
        return m_run && (m_cnt == 0);
    endfunction

    task automatic load_word(input int k);
        frac_word  = ACC_W'(k);
        frac_valid = 1'b1;
        @(negedge clk);
        frac_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; dither_en = 1'b0; frac_valid = 1'b0; frac_word = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (select_mode !== 1'b0) begin n_fail++; $display("FAIL reset_select got=%b exp=0", select_mode); end
        n_checks++;
        if (settled !== 1'b0) begin n_fail++; $display("FAIL reset_settled got=%b exp=0", settled); end
        n_checks++;
        if (frac_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", frac_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (select_mode !== 1'b0 || settled !== 1'b0) begin
            n_fail++; $display("FAIL idle_outputs got sel=%b set=%b exp 0/0", select_mode, settled);
        end
    endtask

    task automatic test_k64();
        int ones = 0;
        enable = 1'b1;
        load_word(64);
        n_checks++;
        if (select_mode !== 1'b0) begin n_fail++; $display("FAIL k64_entry got=%b exp=0", select_mode); end
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            n_checks++;
            if (select_mode !== ((i % 4) == 0)) begin
                n_fail++; $display("FAIL k64_pattern edge=%0d got=%b exp=%b", i, select_mode, (i % 4) == 0);
            end
            if (select_mode === 1'b1) ones++;
            if (i >= 63) begin
                n_checks++;
                if (settled !== (i == 64)) begin
                    n_fail++; $display("FAIL k64_settle edge=%0d got=%b exp=%b", i, settled, i == 64);
                end
            end
        end
        // 16 of 64 cycles at divide-240 -> average 246
        n_checks++;
        if (ones != 16) begin n_fail++; $display("FAIL k64_ratio got=%0d exp=16", ones); end
    endtask

    task automatic test_reload();
        int ones = 0;
        load_word(192);
        n_checks++;
        if (settled !== 1'b0 || select_mode !== m_sel) begin
            n_fail++; $display("FAIL reload_entry got set=%b sel=%b exp set=0 sel=%b", settled, select_mode, m_sel);
        end
        for (int j = 1; j <= 64; j++) begin
            @(negedge clk);
            n_checks++;
            if (select_mode !== m_sel) begin
                n_fail++; $display("FAIL reload_model j=%0d got=%b exp=%b", j, select_mode, m_sel);
            end
            if (j == 1) begin
                n_checks++;
                if (select_mode !== 1'b1) begin n_fail++; $display("FAIL reload_no_acc_clear got=%b exp=1", select_mode); end
            end
            if (j >= 63) begin
                n_checks++;
                if (settled !== (j == 64)) begin
                    n_fail++; $display("FAIL reload_settle j=%0d got=%b exp=%b", j, settled, j == 64);
                end
            end
            if (j >= 5 && select_mode === 1'b1) ones++;
        end
        n_checks++;
        if (ones != 45) begin n_fail++; $display("FAIL reload_ratio got=%0d exp=45", ones); end
    endtask

    task automatic test_k128_k0_k255();
        logic prev;
        int   cnt;
        load_word(128);
        repeat (2) @(negedge clk);
        prev = select_mode;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (select_mode === prev || select_mode !== m_sel) begin
                n_fail++; $display("FAIL k128_alt i=%0d got=%b prev=%b exp=%b", i, select_mode, prev, m_sel);
            end
            prev = select_mode;
        end
        load_word(0);
        repeat (2) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (select_mode !== 1'b0) cnt++;
        end
        n_checks++;
        if (cnt != 0) begin n_fail++; $display("FAIL k0_const got_ones=%0d exp=0", cnt); end
        load_word(255);
        repeat (2) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (select_mode === 1'b0) cnt++;
        end
        n_checks++;
        if (cnt != 1) begin n_fail++; $display("FAIL k255_zeros got=%0d exp=1", cnt); end
    endtask

    task automatic test_enable_drop();
        logic exp_seq [5];
        exp_seq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        enable = 1'b0;
        load_word(200);
        n_checks++;
        if (select_mode !== 1'b0 || settled !== 1'b0) begin
            n_fail++; $display("FAIL drop_outputs got sel=%b set=%b exp 0/0", select_mode, settled);
        end
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        n_checks++;
        if (select_mode !== 1'b0) begin n_fail++; $display("FAIL reenable_entry got=%b exp=0", select_mode); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (select_mode !== exp_seq[i]) begin
                n_fail++; $display("FAIL reenable_seq edge=%0d got=%b exp=%b", i + 1, select_mode, exp_seq[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        load_word(255);
        for (int i = 0; i < 8 && !m_sel; i++) @(negedge clk);
        n_checks++;
        if (select_mode !== 1'b1) begin n_fail++; $display("FAIL pre_reset_select got=%b exp=1", select_mode); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (select_mode !== 1'b0 || settled !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got sel=%b set=%b exp 0/0", select_mode, settled);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 66; i++) begin
            @(negedge clk);
            n_checks++;
            if (select_mode !== 1'b0 || settled !== (i >= 65)) begin
                n_fail++; $display("FAIL post_reset edge=%0d got sel=%b set=%b exp sel=0 set=%b",
                                   i, select_mode, settled, i >= 65);
            end
        end
    endtask

    task automatic test_dither();
        int ones = 0, mism = 0, run = 0, max_run = 0;
        logic prev;
        dither_en = 1'b1;
        load_word(64);
        prev = select_mode;
        for (int i = 0; i < 32768; i++) begin
            @(negedge clk);
            if (select_mode !== m_sel || settled !== m_settled()) mism++;
            if (select_mode === 1'b1) ones++;
            run = (select_mode === prev) ? run + 1 : 1;
            if (run > max_run) max_run = run;
            prev = select_mode;
        end
        n_checks++;
        if (mism != 0) begin n_fail++; $display("FAIL dither_model mismatched_cycles=%0d exp=0", mism); end
        // K/256 share plus half-duty dither bit: (64*32768 + 16384)/256 = 8256
        n_checks++;
        if (ones < 8173 || ones > 8339) begin n_fail++; $display("FAIL dither_count got=%0d exp=8256+/-83", ones); end
        n_checks++;
        if (max_run > 8) begin n_fail++; $display("FAIL dither_run got=%0d exp<=8", max_run); end
        dither_en = 1'b0;
    endtask

    task automatic test_random();
        int sel_mism = 0, set_mism = 0, set_seen = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) enable = ~enable;
            if ($urandom_range(299) == 0) dither_en = ~dither_en;
            frac_valid = ($urandom_range(99) == 0);
            frac_word  = ACC_W'($urandom);
            @(negedge clk);
            if (select_mode !== m_sel) sel_mism++;
            if (settled !== m_settled()) set_mism++;
            if (m_settled()) set_seen++;
        end
        frac_valid = 1'b0;
        n_checks++;
        if (sel_mism != 0) begin n_fail++; $display("FAIL random_select mismatched_cycles=%0d exp=0", sel_mism); end
        n_checks++;
        if (set_mism != 0) begin n_fail++; $display("FAIL random_settled mismatched_cycles=%0d exp=0 (settled cycles=%0d)", set_mism, set_seen); end
    endtask

    initial begin
        test_reset();
        test_k64();
        test_reload();
        test_k128_k0_k255();
        test_enable_drop();
        test_async_reset();
        test_dither();
        enable = 1'b1;
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/modulus_sequencer.md
MODULUS_SEQUENCER -- requirements
Module: modulus_sequencer

Interface
REQ-001 Parameter ACC_W, default 8: width of the fractional word and the accumulator.
REQ-002 Parameter SETTLE_CYCLES, default 64: cycles `settled` stays low after a new word is accepted.
REQ-003 Parameter LFSR_SEED, default 15'h4A5B: non-zero reset seed for the dither LFSR.
REQ-004 clk  in  1  feedback clock, the freq_out of the 240/248 divider; one rising edge per divider output period.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 enable  in  1  1 = run fractional sequencing; 0 = idle at fixed divide-248.
REQ-007 dither_en  in  1  1 = add the LFSR bit into the accumulator LSB.
REQ-008 frac_word  in  ACC_W  fraction K; average ratio = 248 - 8*K/2^ACC_W.
REQ-009 frac_valid  in  1  frac_word is offered this cycle.
REQ-010 frac_ready  out  1  the block accepts a word this cycle.
REQ-011 select_mode  out  1  divider control: 1 = divide-240, 0 = divide-248.
REQ-012 settled  out  1  1 = running, and SETTLE_CYCLES have elapsed since the last accepted word.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and RUN.
REQ-014 IDLE->RUN on a clk edge with enable=1; RUN->IDLE on a clk edge with enable=0.
REQ-015 In IDLE: acc SHALL be held at 0, select_mode=0, settled=0, and the settle counter SHALL be held at SETTLE_CYCLES.
REQ-016 A word SHALL transfer on every edge where frac_valid && frac_ready; frac_ready SHALL be 1 in both states (no backpressure).
REQ-017 The accepted word SHALL be stored in frac_reg; an unaccepted frac_word SHALL be ignored.
REQ-018 In RUN, each edge: {carry, acc} <= acc + frac_reg + (dither_en ? lfsr_bit : 0), using ACC_W+1-bit arithmetic; acc wraps modulo 2^ACC_W.
REQ-019 select_mode SHALL be registered and equal the carry of the previous edge's addition (latency 1 cycle).
REQ-020 frac_reg=0 with dither off SHALL give select_mode=0 permanently.
REQ-021 frac_reg=2^ACC_W-1 with dither off SHALL give select_mode=1 on 2^ACC_W-1 of every 2^ACC_W cycles.
REQ-022 A word accepted in RUN SHALL NOT clear acc.
REQ-023 A word accepted in RUN SHALL be used from the next addition onward.
REQ-024 A word accepted in RUN SHALL reload the settle counter to SETTLE_CYCLES and drive settled=0 from the next cycle.
REQ-025 In RUN, the settle counter SHALL decrement each cycle, saturating at 0.
REQ-026 settled SHALL be 1 while the settle counter is 0 in RUN.
REQ-027 Entering RUN from IDLE SHALL start the settle countdown from SETTLE_CYCLES.
REQ-028 If enable falls in the same cycle a word is accepted, the word SHALL be stored, the state SHALL go to IDLE, and select_mode SHALL be 0 next cycle.
REQ-029 The LFSR SHALL be 15-bit, x^15+x^14+1, and advance only in RUN with dither_en=1.
REQ-030 lfsr_bit SHALL be LFSR bit 0.

Reset
REQ-031 While rst_n=0: state=IDLE, acc=0, frac_reg=0, select_mode=0, settled=0, settle counter=SETTLE_CYCLES, LFSR=LFSR_SEED.
REQ-032 rst_n=0 mid-RUN SHALL force select_mode=0 asynchronously.
REQ-033 After rst_n rises, the first clk edge SHALL behave as IDLE.

Structure
REQ-034 Package modulus_seq_pkg SHALL hold the state enum {IDLE, RUN}, the ACC_W default and the LFSR tap constants.
REQ-035 The LFSR SHALL be a separate sub-module, dsm_lfsr, with ports clk, rst_n, advance and bit_out.
REQ-036 All other logic SHALL be in modulus_sequencer, with a single clock domain.

Verification
REQ-037 Reset, enable=1, K=64, dither off -> select_mode 0,0,0,1 repeating, first 1 on the 5th edge in RUN; average ratio 246.
REQ-038 K=128 -> select_mode alternates 0,1; K=0 -> constant 0 over 1000 cycles; K=255 -> exactly one 0 per 256 cycles.
REQ-039 Running at K=64 and settled=1, load K=192 -> settled=0 next cycle, back to 1 after 64 cycles; no acc reset; pattern becomes 0,1,1,1.
REQ-040 Drop enable while frac_valid=1 -> frac_reg updated, state IDLE, select_mode=0 next cycle; re-enable -> sequence restarts from acc=0.
REQ-041 Assert rst_n=0 mid-sequence between clk edges -> select_mode=0 immediately; all registers at reset values.
REQ-042 dither_en=1, K=64 over 2^15 cycles -> count of select_mode=1 within +/-1% of K/256 plus the LFSR duty contribution; no run of constant output longer than 8 cycles.
